// File: rtl/op_lane_queues_pkg.sv
// Shared defaults and status-bit indices for the VP opcode lane queue.
// Optional sticky error port is enabled with OPQ_ERR_STICKY_EN.
package op_lane_queues_pkg;

    localparam int OPQ_NUM_LANES    = 4;
    localparam int OPQ_LANE_WIDTH   = 64;
    localparam int OPQ_DEPTH_LOG    = 4;
    localparam int OPQ_AFULL_MARGIN = 2;

    // Bit positions inside o_err when the sticky error feature is built in.
    typedef enum int {
        ERR_DROPPED_PUSH = 0,
        ERR_IGNORED_POP  = 1
    } opq_err_bit_e;

endpackage

// File: rtl/op_lane_rptr.sv
// Per-lane read pointer: tracks one lane's head and derives its occupancy
// against the shared write pointer.
module op_lane_rptr #(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DEPTH_LOG:0]   wptr,
    input  logic                 pop,
    input  logic                 flush,
    output logic [DEPTH_LOG-1:0] raddr,
    output logic [DEPTH_LOG:0]   occ,
    output logic                 valid
);

    logic [DEPTH_LOG:0] rptr;

    // One extra pointer bit lets full (occ == depth) be told apart from empty.
    assign occ   = wptr - rptr;
    assign valid = |occ;
    assign raddr = rptr[DEPTH_LOG-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
        end else if (flush) begin
            rptr <= '0;
        end else if (pop && valid) begin
            rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/op_lane_queues.sv
// Multi-lane opcode queue: one shared write pointer, independent per-lane
// read pointers with first-word-fall-through heads. Optional: OPQ_ERR_STICKY_EN.
module op_lane_queues
    import op_lane_queues_pkg::*;
#(
    parameter int NUM_LANES    = OPQ_NUM_LANES,
    parameter int LANE_WIDTH   = OPQ_LANE_WIDTH,
    parameter int DEPTH_LOG    = OPQ_DEPTH_LOG,
    parameter int AFULL_MARGIN = OPQ_AFULL_MARGIN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_flush,
    input  logic                            i_push,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] i_data,
    input  logic [NUM_LANES-1:0]            i_pop,
    output logic [NUM_LANES*LANE_WIDTH-1:0] o_data,
    output logic [NUM_LANES-1:0]            o_valid,
    output logic                            o_empty,
    output logic                            o_full,
    output logic                            o_afull,
    output logic [DEPTH_LOG:0]              o_count
`ifdef OPQ_ERR_STICKY_EN
    ,
    output logic [1:0]                      o_err
`endif
);

    localparam int                 DEPTH     = 1 << DEPTH_LOG;
    localparam int                 ENTRY_W   = NUM_LANES * LANE_WIDTH;
    localparam logic [DEPTH_LOG:0] FULL_CNT  = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] AFULL_CNT = (DEPTH_LOG+1)'(DEPTH - AFULL_MARGIN);

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG:0]   wptr;
    logic [DEPTH_LOG-1:0] raddr [NUM_LANES];
    logic [DEPTH_LOG:0]   occ [NUM_LANES];
    logic                 push_ok;

    // Full is judged on start-of-cycle state, so a same-cycle pop never frees a slot.
    assign push_ok = i_push && !o_full && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wptr[DEPTH_LOG-1:0]] <= i_data;
            end
            if (i_flush) begin
                wptr <= '0;
            end else if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        op_lane_rptr #(
            .DEPTH_LOG (DEPTH_LOG)
        ) u_rptr (
            .clk   (clk),
            .rst   (rst),
            .wptr  (wptr),
            .pop   (i_pop[l]),
            .flush (i_flush),
            .raddr (raddr[l]),
            .occ   (occ[l]),
            .valid (o_valid[l])
        );

        assign o_data[l*LANE_WIDTH +: LANE_WIDTH] = mem[raddr[l]][l*LANE_WIDTH +: LANE_WIDTH];
    end

    always_comb begin
        o_count = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (occ[l] > o_count) begin
                o_count = occ[l];
            end
        end
    end

    assign o_empty = ~|o_valid;
    assign o_full  = (o_count == FULL_CNT);
    assign o_afull = (o_count >= AFULL_CNT);

`ifdef OPQ_ERR_STICKY_EN
    // Flush clears the sticky bits and masks that cycle's push/pop attempts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err <= '0;
        end else if (i_flush) begin
            o_err <= '0;
        end else begin
            if (i_push && o_full) begin
                o_err[ERR_DROPPED_PUSH] <= 1'b1;
            end
            if (|(i_pop & ~o_valid)) begin
                o_err[ERR_IGNORED_POP] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_op_lane_queues.sv
// Self-checking bench for op_lane_queues: directed plan steps followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_op_lane_queues;

    localparam int NL = 4;
    localparam int LW = 64;
    localparam int W  = NL * LW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_flush = 1'b0;
    logic          i_push = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic [NL-1:0] i_pop = '0;
    logic [W-1:0]  o_data;
    logic [NL-1:0] o_valid;
    logic          o_empty;
    logic          o_full;
    logic          o_afull;
    logic [4:0]    o_count;
`ifdef OPQ_ERR_STICKY_EN
    logic [1:0]    o_err;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: every accepted entry in push order, plus how many
    // entries each lane has consumed since the last clear.
    logic [W-1:0] hist [$];
    int           wc;
    int           rc [NL];
    logic [1:0]   merr;

    op_lane_queues dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_flush),
        .i_push  (i_push),
        .i_data  (i_data),
        .i_pop   (i_pop),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_empty (o_empty),
        .o_full  (o_full),
        .o_afull (o_afull),
        .o_count (o_count)
`ifdef OPQ_ERR_STICKY_EN
        ,
        .o_err   (o_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int k);
        logic [W-1:0] d;
        for (int l = 0; l < NL; l++) d[l*LW +: LW] = 64'(k * 16 + l);
        return d;
    endfunction

    function automatic logic [W-1:0] rnd_entry();
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int model_max();
        int mx = 0;
        for (int l = 0; l < NL; l++) if (wc - rc[l] > mx) mx = wc - rc[l];
        return mx;
    endfunction

    task automatic model_clear();
        hist.delete();
        wc = 0;
        for (int l = 0; l < NL; l++) rc[l] = 0;
        merr = 2'b00;
    endtask

    task automatic check_outputs(input string tag);
        int mx;
        logic [NL-1:0] ev;
        mx = model_max();
        for (int l = 0; l < NL; l++) ev[l] = (wc - rc[l]) != 0;
        chk({tag, ".valid"}, W'(o_valid), W'(ev));
        chk({tag, ".empty"}, W'(o_empty), W'(ev == 0));
        chk({tag, ".count"}, W'(o_count), W'(mx));
        chk({tag, ".full"},  W'(o_full),  W'(mx == DEPTH));
        chk({tag, ".afull"}, W'(o_afull), W'(mx >= DEPTH - 2));
        for (int l = 0; l < NL; l++) begin
            if (ev[l]) chk($sformatf("%s.data%0d", tag, l), W'(o_data[l*LW +: LW]), W'(hist[rc[l]][l*LW +: LW]));
        end
`ifdef OPQ_ERR_STICKY_EN
        chk({tag, ".err"}, W'(o_err), W'(merr));
`endif
    endtask

    // Applies one cycle of inputs, advances the model across the edge, checks.
    task automatic step(input string tag, input logic push, input logic [W-1:0] data,
                        input logic [NL-1:0] pop, input logic flush);
        bit full_now;
        bit empty_lane [NL];
        full_now = model_max() == DEPTH;
        for (int l = 0; l < NL; l++) empty_lane[l] = (wc - rc[l]) == 0;
        i_push  = push;
        i_data  = data;
        i_pop   = pop;
        i_flush = flush;
        @(posedge clk);
        #1;
        if (flush) begin
            model_clear();
        end else begin
            if (push && full_now) merr[0] = 1'b1;
            if (push && !full_now) begin
                hist.push_back(data);
                wc++;
            end
            for (int l = 0; l < NL; l++) begin
                if (pop[l] && empty_lane[l]) merr[1] = 1'b1;
                if (pop[l] && !empty_lane[l]) rc[l]++;
            end
        end
        i_push  = 1'b0;
        i_pop   = '0;
        i_flush = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.empty", W'(o_empty), W'(1'b1));
        chk("rst.valid", W'(o_valid), W'(4'b0000));
        chk("rst.count", W'(o_count), W'(0));
        chk("rst.full",  W'(o_full),  W'(1'b0));
        chk("rst.afull", W'(o_afull), W'(1'b0));
        chk("rst.data",  o_data, '0);
        check_outputs("idle");

        // Fill all 16 slots without popping.
        for (int k = 0; k < 16; k++) begin
            step($sformatf("fill%0d", k), 1'b1, mk(k), 4'b0000, 1'b0);
            if (k == 12) chk("afull_after13", W'(o_afull), W'(1'b0));
            if (k == 13) chk("afull_after14", W'(o_afull), W'(1'b1));
            if (k == 14) chk("full_after15",  W'(o_full),  W'(1'b0));
        end
        chk("full_after16", W'(o_full), W'(1'b1));
        step("push17", 1'b1, mk(99), 4'b0000, 1'b0);
        chk("count_after17", W'(o_count), W'(16));

        // Drain lane 2 alone.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("lane2_head%0d", k), W'(o_data[2*LW +: LW]), W'(k * 16 + 2));
            step($sformatf("pop2_%0d", k), 1'b0, '0, 4'b0100, 1'b0);
        end
        chk("lane2_valid", W'(o_valid), W'(4'b1011));
        chk("lane2_full",  W'(o_full),  W'(1'b1));

        // Steady push+pop across pointer wrap from occupancy 3.
        step("flush_a", 1'b0, '0, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) step("pre3", 1'b1, mk(20 + k), 4'b0000, 1'b0);
        for (int k = 0; k < 40; k++) step($sformatf("wrap%0d", k), 1'b1, mk(30 + k), 4'b1111, 1'b0);
        chk("wrap_count", W'(o_count), W'(3));

        // Flush discards a same-cycle push and pops.
        for (int k = 0; k < 6; k++) step("to9", 1'b1, mk(80 + k), 4'b0000, 1'b0);
        chk("count9", W'(o_count), W'(9));
        step("flush_b", 1'b1, mk(90), 4'b1111, 1'b1);
        chk("flush_empty", W'(o_empty), W'(1'b1));
        chk("flush_count", W'(o_count), W'(0));

        // Pop on empty lanes, build occupancy 5, then reset mid-cycle.
        step("pop_empty", 1'b1, mk(100), 4'b1111, 1'b0);
`ifdef OPQ_ERR_STICKY_EN
        chk("err_pop_empty", W'(o_err), W'(2'b10));
`endif
        chk("pop_empty_data", W'(o_data[0 +: LW]), W'(100 * 16));
        for (int k = 1; k < 5; k++) step("to5", 1'b1, mk(100 + k), 4'b0000, 1'b0);
        chk("count5", W'(o_count), W'(5));
        #2;
        rst = 1'b1;
        #1;
        chk("arst.empty", W'(o_empty), W'(1'b1));
        chk("arst.valid", W'(o_valid), W'(4'b0000));
        chk("arst.count", W'(o_count), W'(0));
        chk("arst.full",  W'(o_full),  W'(1'b0));
        chk("arst.afull", W'(o_afull), W'(1'b0));
        chk("arst.data",  o_data, '0);
`ifdef OPQ_ERR_STICKY_EN
        chk("arst.err",   W'(o_err), W'(2'b00));
`endif
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("post_rst");

        // Randomized traffic with alternating push bias so full and empty both occur.
        for (int i = 0; i < 2000; i++) begin
            int bias;
            logic [NL-1:0] p;
            bias = ((i / 150) % 2 == 0) ? 80 : 30;
            for (int l = 0; l < NL; l++) p[l] = ($urandom_range(0, 99) < 45);
            step($sformatf("rnd%0d", i), $urandom_range(0, 99) < bias, rnd_entry(), p,
                 $urandom_range(0, 249) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
